// File: rtl/niossystem_onchip_mem_arbiter_pkg.sv
// Shared widths, range limit and enums for the on-chip RAM arbiter.
package niosSystem_mem_arb_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int DEPTH  = 5100;
  localparam int BCNT_W = 4;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic {
    PORT_CPU   = 1'b0,
    PORT_AUDIO = 1'b1
  } port_e;

  typedef enum logic {
    FAVOR_AUDIO = 1'b0,
    FAVOR_CPU   = 1'b1
  } favor_e;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
    return addr >= DEPTH_A;
  endfunction
endpackage

// File: rtl/niossystem_onchip_mem_arbiter_if.sv
// Avalon-MM pipelined master port as seen by the RAM arbiter.
interface niossystem_onchip_mem_arbiter_if;
  import niosSystem_mem_arb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  // Handshake: a request (read | write) is accepted in any cycle where it is
  // asserted and waitrequest is low; the master must hold it stable otherwise.
  // readdatavalid qualifies readdata exactly one cycle after a read is accepted.
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/niossystem_onchip_mem_arbiter_grant.sv
// Favor FSM and burst counter: audio has priority, but after MAX_BURST
// consecutive audio grants over a waiting CPU the CPU gets one turn.
module niosSystem_mem_arb_grant
  import niosSystem_mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  output logic              grant0,
  output logic              grant1,
  output favor_e            favor,
  output logic [BCNT_W-1:0] bcnt
);
  localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BURST);

  favor_e            favor_q, favor_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      favor_q <= FAVOR_AUDIO;
      bcnt_q  <= '0;
    end else begin
      favor_q <= favor_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    favor_d = favor_q;
    bcnt_d  = bcnt_q;

    if (!reset) begin
      case (favor_q)
        FAVOR_AUDIO: begin
          if (req1)      grant1 = 1'b1;
          else if (req0) grant0 = 1'b1;
        end
        FAVOR_CPU: begin
          if (req0)      grant0 = 1'b1;
          else if (req1) grant1 = 1'b1;
        end
        default: ;
      endcase
    end

    // Only audio grants that starve a waiting CPU count; the count saturates.
    if (grant0 || !req0)
      bcnt_d = '0;
    else if (grant1 && bcnt_q != '1)
      bcnt_d = bcnt_q + 1'b1;

    if (favor_q == FAVOR_CPU) begin
      if (grant0 || grant1) begin
        favor_d = FAVOR_AUDIO;
        bcnt_d  = '0;
      end
    end else if (bcnt_d >= MAX_B) begin
      favor_d = FAVOR_CPU;
    end
  end

  assign favor = favor_q;
  assign bcnt  = bcnt_q;
endmodule

// File: rtl/niossystem_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between the Nios data master (m0) and
// the audio delay-line engine (m1), returning reads with one-cycle latency.
module niossystem_onchip_mem_arbiter
  import niosSystem_mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  niossystem_onchip_mem_arbiter_if.slave m0,
  niossystem_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [BE_W-1:0]       mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  range_err,
  output favor_e                dbg_favor,
  output logic [BCNT_W-1:0]     dbg_bcnt
);
  logic req0, req1, grant0, grant1, any_grant;
  logic [ADDR_W-1:0] win_addr;
  logic              win_wr, win_oor;

  logic  rd_valid, rd_oor, ret_ok;
  port_e rd_port;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  niosSystem_mem_arb_grant #(.MAX_BURST(MAX_BURST)) u_grant (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .grant0 (grant0),
    .grant1 (grant1),
    .favor  (dbg_favor),
    .bcnt   (dbg_bcnt)
  );

  assign any_grant = grant0 | grant1;

  assign m0.waitrequest = req0 & ~grant0;
  assign m1.waitrequest = req1 & ~grant1;

  always_comb begin
    win_addr       = grant1 ? m1.address    : m0.address;
    win_wr         = grant1 ? m1.write      : m0.write;
    mem_byteenable = grant1 ? m1.byteenable : m0.byteenable;
    mem_writedata  = grant1 ? m1.writedata  : m0.writedata;
  end

  // Out-of-range accesses never reach the RAM; reads are answered with zero.
  assign win_oor        = out_of_range(win_addr);
  assign mem_address    = win_addr;
  assign mem_chipselect = any_grant & ~win_oor;
  assign mem_write      = any_grant & win_wr & ~win_oor;
  assign mem_clken      = 1'b1;
  assign range_err      = any_grant & win_oor;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_port  <= PORT_CPU;
      rd_oor   <= 1'b0;
    end else begin
      rd_valid <= any_grant & ~win_wr;
      rd_port  <= grant1 ? PORT_AUDIO : PORT_CPU;
      rd_oor   <= win_oor;
    end
  end

  // Reset squashes a return that is already in flight this cycle.
  assign ret_ok = rd_valid & ~reset;

  assign m0.readdatavalid = ret_ok & (rd_port == PORT_CPU);
  assign m1.readdatavalid = ret_ok & (rd_port == PORT_AUDIO);
  assign m0.readdata      = (m0.readdatavalid & ~rd_oor) ? mem_readdata : '0;
  assign m1.readdata      = (m1.readdatavalid & ~rd_oor) ? mem_readdata : '0;
endmodule

// File: tb/tb_niossystem_onchip_mem_arbiter.sv
// Directed bench for the on-chip RAM arbiter with a behavioural one-cycle RAM.
module tb_niossystem_onchip_mem_arbiter;
  import niosSystem_mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  niossystem_onchip_mem_arbiter_if m0_bus ();
  niossystem_onchip_mem_arbiter_if m1_bus ();

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken, range_err;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;
  favor_e            dbg_favor;
  logic [BCNT_W-1:0] dbg_bcnt;

  niossystem_onchip_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .range_err      (range_err),
    .dbg_favor      (dbg_favor),
    .dbg_bcnt       (dbg_bcnt)
  );

  // ---------------- RAM model ----------------
  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 | {19'b0, a};
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  logic [DATA_W-1:0] ram [0:8191];
  logic [DATA_W-1:0] ram_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8192; i++) ram[i] <= init_word(ADDR_W'(i));
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      ram_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_q;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n_rdv1 = 0;
  logic [DATA_W-1:0] exp_q[$];
  port_e             exp_port_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_read(input port_e p, input logic [DATA_W-1:0] d);
    exp_port_q.push_back(p);
    exp_q.push_back(d);
  endtask

  // Advance to the next sampling point and check read returns owed from the
  // previous cycle.
  task automatic tick();
    logic              has;
    port_e             p;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    has = 1'b0;
    p   = PORT_CPU;
    d   = '0;
    if (exp_q.size() > 0) begin
      has = 1'b1;
      p   = exp_port_q.pop_front();
      d   = exp_q.pop_front();
    end
    if (m1_bus.readdatavalid) n_rdv1++;
    check("rdv0", 32'(m0_bus.readdatavalid), 32'(has && p == PORT_CPU));
    check("rdv1", 32'(m1_bus.readdatavalid), 32'(has && p == PORT_AUDIO));
    check("rd0", m0_bus.readdata, (has && p == PORT_CPU) ? d : 32'd0);
    check("rd1", m1_bus.readdata, (has && p == PORT_AUDIO) ? d : 32'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_m0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
    m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
    m0_bus.byteenable = be; m0_bus.writedata = wd;
  endtask

  task automatic drive_m1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
    m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
    m1_bus.byteenable = be; m1_bus.writedata = wd;
  endtask

  task automatic idle_all();
    drive_m0(1'b0, 1'b0, '0, 4'hF, '0);
    drive_m1(1'b0, 1'b0, '0, 4'hF, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_all();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Requests under reset are held off.
    drive_m1(1'b1, 1'b0, 13'h0010, 4'hF, '0);
    #1;
    check("rst_wait1", 32'(m1_bus.waitrequest), 32'd1);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_we", 32'(mem_write), 32'd0);
    check("rst_clken", 32'(mem_clken), 32'd1);
    check("rst_rdv1", 32'(m1_bus.readdatavalid), 32'd0);
    check("rst_rd1", m1_bus.readdata, 32'd0);
    check("rst_rerr", 32'(range_err), 32'd0);
    check("rst_favor", 32'(dbg_favor), 32'(FAVOR_AUDIO));
    check("rst_bcnt", 32'(dbg_bcnt), 32'd0);

    // m1 streams reads of 0x0010 at full rate.
    n_rdv1 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      reset = 1'b0;
      drive_m1(1'b1, 1'b0, 13'h0010, 4'hF, '0);
      #1;
      check("s_wait1", 32'(m1_bus.waitrequest), 32'd0);
      check("s_wait0", 32'(m0_bus.waitrequest), 32'd0);
      check("s_cs", 32'(mem_chipselect), 32'd1);
      expect_read(PORT_AUDIO, 32'hC0DE_0010);
    end
    tick();
    idle_all();
    #1;
    check("s_pulses", 32'(n_rdv1), 32'd20);

    // Both ports saturate: grants go 1,1,1,1,0; then four more audio grants
    // leave the arbiter favoring the CPU with bcnt = 4.
    for (int k = 0; k < 19; k++) begin
      tick();
      drive_m0(1'b1, 1'b0, 13'h0020, 4'hF, '0);
      drive_m1(1'b1, 1'b0, 13'h0030, 4'hF, '0);
      #1;
      check("b_wait0", 32'(m0_bus.waitrequest), (k % 5 == 4) ? 32'd0 : 32'd1);
      check("b_wait1", 32'(m1_bus.waitrequest), (k % 5 == 4) ? 32'd1 : 32'd0);
      if (k % 5 == 4) expect_read(PORT_CPU, 32'hC0DE_0020);
      else            expect_read(PORT_AUDIO, 32'hC0DE_0030);
    end

    // Reset lands while the last audio read is in flight.
    @(negedge clk);
    reset = 1'b1;
    drive_m1(1'b0, 1'b0, '0, 4'hF, '0);
    #1;
    check("mid_favor", 32'(dbg_favor), 32'(FAVOR_CPU));
    check("mid_bcnt", 32'(dbg_bcnt), 32'd4);
    check("mid_rdv1", 32'(m1_bus.readdatavalid), 32'd0);
    check("mid_rd1", m1_bus.readdata, 32'd0);
    check("mid_rdv0", 32'(m0_bus.readdatavalid), 32'd0);
    check("mid_wait0", 32'(m0_bus.waitrequest), 32'd1);
    check("mid_cs", 32'(mem_chipselect), 32'd0);
    exp_q.delete();
    exp_port_q.delete();
    tick();
    check("post_favor", 32'(dbg_favor), 32'(FAVOR_AUDIO));
    check("post_bcnt", 32'(dbg_bcnt), 32'd0);
    reset = 1'b0;
    idle_all();

    // Partial write followed immediately by a read of the same word.
    tick();
    drive_m0(1'b0, 1'b1, 13'h0100, 4'b0011, 32'hDEAD_BEEF);
    #1;
    check("wr_wait0", 32'(m0_bus.waitrequest), 32'd0);
    check("wr_cs", 32'(mem_chipselect), 32'd1);
    check("wr_we", 32'(mem_write), 32'd1);
    check("wr_addr", 32'(mem_address), 32'h0100);
    check("wr_be", 32'(mem_byteenable), 32'h3);
    check("wr_data", mem_writedata, 32'hDEAD_BEEF);
    check("wr_rerr", 32'(range_err), 32'd0);
    tick();
    drive_m0(1'b0, 1'b0, '0, 4'hF, '0);
    drive_m1(1'b1, 1'b0, 13'h0100, 4'hF, '0);
    #1;
    check("raw_wait1", 32'(m1_bus.waitrequest), 32'd0);
    expect_read(PORT_AUDIO, 32'hC0DE_BEEF);
    tick();
    idle_all();

    // Out-of-range read then write at address 5100.
    drive_m0(1'b1, 1'b0, 13'd5100, 4'hF, '0);
    #1;
    check("oor_rerr", 32'(range_err), 32'd1);
    check("oor_cs", 32'(mem_chipselect), 32'd0);
    check("oor_wait0", 32'(m0_bus.waitrequest), 32'd0);
    expect_read(PORT_CPU, 32'd0);
    tick();
    drive_m0(1'b0, 1'b1, 13'd5100, 4'hF, 32'hFFFF_FFFF);
    #1;
    check("oorw_rerr", 32'(range_err), 32'd1);
    check("oorw_cs", 32'(mem_chipselect), 32'd0);
    check("oorw_we", 32'(mem_write), 32'd0);
    check("oorw_wait0", 32'(m0_bus.waitrequest), 32'd0);
    tick();
    idle_all();
    #1;
    check("idle_rerr", 32'(range_err), 32'd0);
    check("oorw_ram", ram[5100], 32'hC0DE_13EC);

    // Read and write together behave as a write.
    tick();
    drive_m0(1'b1, 1'b1, 13'h0002, 4'hF, 32'h1122_3344);
    #1;
    check("rw_we", 32'(mem_write), 32'd1);
    check("rw_cs", 32'(mem_chipselect), 32'd1);
    check("rw_wait0", 32'(m0_bus.waitrequest), 32'd0);
    tick();
    drive_m0(1'b0, 1'b0, '0, 4'hF, '0);
    drive_m1(1'b1, 1'b0, 13'h0002, 4'hF, '0);
    #1;
    expect_read(PORT_AUDIO, 32'h1122_3344);
    tick();
    idle_all();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/niossystem_onchip_mem_arbiter.md
# niosSystem_onchip_mem_arbiter

Two-master arbiter that shares the single-port on-chip RAM (5100 × 32-bit words, 13-bit word address, byte enables, one-cycle read latency) between the Nios data master (port 0) and the audio delay-line engine (port 1). Audio has priority, and a burst limit bounds CPU starvation. The arbiter registers read-return routing, so each master sees Avalon-MM pipelined semantics: waitrequest plus readdatavalid. It sits between the system interconnect and the RAM's chipselect/write/clken inputs.

## Interface
- ADDR_W, 13, word address width
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 5100, valid words; addresses ≥ DEPTH are out of range
- MAX_BURST, 4, maximum consecutive port-1 grants while port 0 is pending (legal range 1..15)
- clk  in  1  system clock; the block uses one clock only
- reset  in  1  synchronous, active-high reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  4  byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  32  write data
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  32  read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  4  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  32  to RAM
- mem_clken  out  1  RAM clock enable; tied to 1
- mem_readdata  in  32  from RAM; valid the cycle after the address is issued
- range_err  out  1  one-cycle pulse when an out-of-range access is accepted

## Operation
- reqN = mN_read | mN_write. A request with both read and write set is treated as a write.
- Arbitration state: `favor` ∈ {AUDIO, CPU} and a 4-bit burst counter `bcnt`.
- In AUDIO state:
  - req1 wins if present; otherwise req0 wins.
  - Each port-1 grant with req0 pending increments bcnt.
  - When bcnt reaches MAX_BURST, the next state is CPU.
- In CPU state:
  - req0 wins if present; otherwise req1 wins.
  - Any grant returns the state to AUDIO with bcnt = 0.
- A port-0 grant, or a cycle with no req0, clears bcnt.
- mN_waitrequest = reqN & ~grantN, computed combinationally. With no request, waitrequest is 0.
- Granted access: drive mem_* from the winner with mem_chipselect = 1 and mem_write = winner's write.
- Out-of-range write (address ≥ DEPTH): chipselect is held 0, the write is dropped, and range_err pulses.
- Out-of-range read: accepted; readdatavalid is returned with readdata = 0, and range_err pulses.
- Read return pipeline: one register holds {valid, port, oor}. On the next cycle, the selected port's readdatavalid = 1 and readdata = mem_readdata (or 0 if oor). The non-selected port's readdata is held at 0.
- Masters hold all request signals stable while waitrequest = 1.

## Timing
- Grant latency: 0 cycles. An access is accepted in the same cycle it is requested, if it wins.
- Read latency: accepted at cycle N → readdatavalid at N+1. Back-to-back reads every cycle are supported at full rate, from either port or interleaved.
- Write at N, read of the same address accepted at N+1: the read returns the new data at N+2.
- Reset values:
  - favor = AUDIO, bcnt = 0, read pipe valid = 0.
  - All readdatavalid = 0, readdata = 0, range_err = 0.
  - mem_chipselect = 0, mem_write = 0, mem_clken = 1.
  - While reset = 1, both waitrequests = 1 when requesting, and no grants are issued.
- Reset asserted mid-read: the pending readdatavalid is squashed, and the next cycle shows 0.
- Simultaneous req0 and req1 in AUDIO state with bcnt < MAX_BURST: port 1 wins and port 0 waits.
- bcnt saturates and never wraps.

## Structure
- Package `niosSystem_mem_arb_pkg` holds:
  - ADDR_W, DATA_W, DEPTH
  - enum {PORT_CPU, PORT_AUDIO}
  - enum {FAVOR_AUDIO, FAVOR_CPU}
- Sub-module `niosSystem_mem_arb_grant` holds the favor FSM, the burst counter, and the grant vector.
- The top level holds the mux, range check, and read-return register.

## Test plan
- Reset release, with m1 reading addr 0x0010 every cycle for 20 cycles and m0 idle → m1_waitrequest = 0 throughout; 20 readdatavalid pulses, each at N+1.
- MAX_BURST = 4, with m1 and m0 both requesting continuously → grant pattern 1,1,1,1,0 repeating; m0 waits exactly 4 cycles per grant.
- m0 writes 0xDEADBEEF to 0x0100 with byteenable 0b0011, then m1 reads 0x0100 → readdata lower 16 bits = 0xBEEF; upper bytes are unchanged from the prior contents.
- m0 reads addr 5100 → range_err pulses, m0_readdatavalid = 1 at N+1 with readdata 0, and mem_chipselect = 0 for a write to 5100.
- Read accepted at N, with reset asserted at N+1 → no readdatavalid at N+1; the state returns to AUDIO with bcnt = 0.
- m0 asserts read and write together to 0x0002 → treated as a write; no readdatavalid.
